// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, instruction type and the NOP
// encoding (addi x0, x0, 0) presented when no instruction is available.
package core_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] instr_t;

  localparam instr_t NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush for the fetch prefetch queue.
// DEPTH must be a power of two so the pointers wrap naturally.
// The caller never writes when full and never reads when empty.
// flush takes priority over any write or read in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  // Next pointer/occupancy: flush empties, otherwise step on write/read.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit with a prefetch queue.
// Optional build macro: IFETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
//
// Handshake: the head entry is offered with instr_valid; it is consumed only in
// a cycle where instr_valid && instr_ready are both high and no redirect is
// present. instr_ready with instr_valid low has no effect.
// Memory: a request in cycle t returns imem_rdata in cycle t+1, and the pair
// {imem_rdata, pc} is enqueued at the end of t+1. Requests are credit
// limited so queued + in-flight never exceeds DEPTH.
module instr_fetch
  import core_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output instr_t          instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);
  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam int             EW      = 2 * XLEN;
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_rdata;
  logic            enq, deq;

  // Credits come from registered occupancy only, so a dequeue this cycle
  // does not open a slot until the next cycle.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign imem_req    = !rst && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc_q;

  // A redirect wins over both the returning response and a dequeue.
  assign enq = inflight_q && !redirect_valid;
  assign deq = instr_valid && instr_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (enq),
    .wr_data ({imem_rdata, inflight_pc_q}),
    .rd_en   (deq),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? fifo_rdata[EW-1:XLEN] : NOP;
  assign instr_pc    = instr_valid ? fifo_rdata[XLEN-1:0] : last_pc_q;

  // Next fetch address, in-flight tracking and held head pc.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = imem_req;
    last_pc_d     = last_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_req) begin
      fetch_pc_d    = fetch_pc_q + 32'd1;
      inflight_pc_d = fetch_pc_q;
    end
    if (instr_valid) last_pc_d = fifo_rdata[XLEN-1:0];
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      last_pc_q     <= RESET_PC;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      last_pc_q     <= last_pc_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Count issued requests, and entries plus in-flight dropped by a redirect.
  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, imem_req};
    perf_flush_d = perf_flush_q;
    if (redirect_valid) perf_flush_d = perf_flush_q + 32'(credit_used);
  end

  // Performance counter registers (wrap naturally).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  // Performance counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch (DEPTH=4, RESET_PC=0).
// Memory responder returns addr+100 one cycle after each request.
module tb_instr_fetch;
  import core_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_ready = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  instr_fetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Instruction memory: data for the word requested last cycle.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr + 32'd100) : 32'hDEAD_BEEF;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two cycles; returns at the start of cycle 0 after release.
  task automatic do_reset(input logic ready);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = ready;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b0, RESET_PC}) begin
      n_fail++;
      $display("FAIL reset_req: got %b/%h want 0/%h", imem_req, imem_addr, RESET_PC);
    end
    n_cmp++;
    if ({instr_valid, instr_pc, instr} !== {1'b0, RESET_PC, NOP}) begin
      n_fail++;
      $display("FAIL reset_head: got %b/%h/%h want 0/%h/%h", instr_valid, instr_pc, instr, RESET_PC, NOP);
    end
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if ({perf_fetch_cnt, perf_flush_cnt} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_reset_release();
    logic        ev;
    logic [31:0] ep, ei;
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ev = (c >= 2);
      ep = ev ? 32'(c - 2) : RESET_PC;
      ei = ev ? ep + 32'd100 : NOP;
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {ev, ep, ei}) begin
        n_fail++;
        $display("FAIL release_head c%0d: got %b/%h/%h want %b/%h/%h", c, instr_valid, instr_pc, instr, ev, ep, ei);
      end
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(c)}) begin
        n_fail++;
        $display("FAIL release_req c%0d: got %b/%h want 1/%h", c, imem_req, imem_addr, 32'(c));
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int          reqs = 0;
    logic [31:0] ep;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== (c < 4)) begin
        n_fail++;
        $display("FAIL bp_req c%0d: got %b want %b", c, imem_req, (c < 4));
      end
      if (imem_req) reqs++;
      if (c >= 2) begin
        n_cmp++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'd100}) begin
          n_fail++;
          $display("FAIL bp_hold c%0d: got %b/%h/%h want 1/0/64", c, instr_valid, instr_pc, instr);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (reqs != 4) begin
      n_fail++;
      $display("FAIL bp_req_count: got %0d want 4", reqs);
    end
    instr_ready = 1'b1;
    for (int c = 10; c < 18; c++) begin
      @(negedge clk);
      ep = 32'(c - 10);
      n_cmp++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, ep, ep + 32'd100}) begin
        n_fail++;
        $display("FAIL bp_drain c%0d: got %b/%h/%h want 1/%h/%h", c, instr_valid, instr_pc, instr, ep, ep + 32'd100);
      end
      if (c == 10) begin
        n_cmp++;
        if (imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_no_same_cycle_credit: got %b want 0", imem_req);
        end
      end
      if (c == 11) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd4}) begin
          n_fail++;
          $display("FAIL bp_resume: got %b/%h want 1/4", imem_req, imem_addr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_flush();
    logic [31:0] ep;
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) next_cycle();
    // cycle 4: three entries queued, one response in flight
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_req_during_redirect: got %b want 0", imem_req);
    end
    next_cycle();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
`ifdef IFETCH_PERF_EN
    @(negedge clk);
    n_cmp++;
    if ({perf_fetch_cnt, perf_flush_cnt} !== {32'd4, 32'd4}) begin
      n_fail++;
      $display("FAIL flush_perf: got %0d/%0d want 4/4", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
    for (int c = 5; c < 10; c++) begin
      @(negedge clk);
      if (c < 7) begin
        n_cmp++;
        if ({instr_valid, instr_pc, instr} !== {1'b0, 32'h0, NOP}) begin
          n_fail++;
          $display("FAIL flush_gap c%0d: got %b/%h/%h want 0/0/%h", c, instr_valid, instr_pc, instr, NOP);
        end
      end else begin
        ep = 32'h40 + 32'(c - 7);
        n_cmp++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, ep, ep + 32'd100}) begin
          n_fail++;
          $display("FAIL flush_target c%0d: got %b/%h/%h want 1/%h/%h", c, instr_valid, instr_pc, instr, ep, ep + 32'd100);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
          n_fail++;
          $display("FAIL flush_first_req: got %b/%h want 1/40", imem_req, imem_addr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_dequeue();
    logic [31:0] ep;
    do_reset(1'b1);
    for (int c = 0; c < 5; c++) next_cycle();
    // cycle 5: head pc 3 valid and ready, redirect also present
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, instr_pc, imem_req} !== {1'b1, 32'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_head: got %b/%h/%b want 1/3/0", instr_valid, instr_pc, imem_req);
    end
    next_cycle();
    redirect_valid = 1'b0;
    for (int c = 6; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) begin
        n_cmp++;
        if ({instr_valid, instr_pc, instr} !== {1'b0, 32'd3, NOP}) begin
          n_fail++;
          $display("FAIL rd_gap c%0d: got %b/%h/%h want 0/3/%h", c, instr_valid, instr_pc, instr, NOP);
        end
      end else begin
        ep = 32'h80 + 32'(c - 8);
        n_cmp++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, ep, ep + 32'd100}) begin
          n_fail++;
          $display("FAIL rd_target c%0d: got %b/%h/%h want 1/%h/%h", c, instr_valid, instr_pc, instr, ep, ep + 32'd100);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] ep;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    next_cycle();
    redirect_valid = 1'b0;
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      if (k < 3) begin
        n_cmp++;
        if ({instr_valid, instr} !== {1'b0, NOP}) begin
          n_fail++;
          $display("FAIL wrap_gap k%0d: got %b/%h want 0/%h", k, instr_valid, instr, NOP);
        end
      end else begin
        ep = 32'hFFFF_FFFE + 32'(k - 3);
        n_cmp++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, ep, ep + 32'd100}) begin
          n_fail++;
          $display("FAIL wrap_seq k%0d: got %b/%h/%h want 1/%h/%h", k, instr_valid, instr_pc, instr, ep, ep + 32'd100);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
          n_fail++;
          $display("FAIL wrap_addr: got %b/%h want 1/0", imem_req, imem_addr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ep;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_req0: got %b want 0", imem_req);
    end
    next_cycle();
    redirect_pc = 32'h200;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_req1: got %b want 0", imem_req);
    end
    next_cycle();
    redirect_valid = 1'b0;
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
          n_fail++;
          $display("FAIL b2b_first_req: got %b/%h want 1/200", imem_req, imem_addr);
        end
      end
      if (k < 4) begin
        n_cmp++;
        if (instr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_gap k%0d: got %b want 0", k, instr_valid);
        end
      end else begin
        ep = 32'h200 + 32'(k - 4);
        n_cmp++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, ep, ep + 32'd100}) begin
          n_fail++;
          $display("FAIL b2b_seq k%0d: got %b/%h/%h want 1/%h/%h", k, instr_valid, instr_pc, instr, ep, ep + 32'd100);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_full();
    logic        ev;
    logic [31:0] ep;
    do_reset(1'b0);
    for (int c = 0; c < 6; c++) next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, imem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL rf_full: got %b/%b want 1/0", instr_valid, imem_req);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({instr_valid, imem_req, imem_addr, instr_pc, instr} !== {1'b0, 1'b0, RESET_PC, RESET_PC, NOP}) begin
      n_fail++;
      $display("FAIL rf_in_reset: got %b/%b/%h/%h/%h want 0/0/%h/%h/%h", instr_valid, imem_req, imem_addr, instr_pc, instr, RESET_PC, RESET_PC, NOP);
    end
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if ({perf_fetch_cnt, perf_flush_cnt} !== 64'h0) begin
      n_fail++;
      $display("FAIL rf_perf: got %h/%h want 0/0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
    do_reset(1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ev = (c >= 2);
      ep = ev ? 32'(c - 2) : RESET_PC;
      n_cmp++;
      if ({instr_valid, instr_pc, imem_addr} !== {ev, ep, 32'(c)}) begin
        n_fail++;
        $display("FAIL rf_restart c%0d: got %b/%h/%h want %b/%h/%h", c, instr_valid, instr_pc, imem_addr, ev, ep, 32'(c));
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_backpressure();
    test_redirect_flush();
    test_redirect_dequeue();
    test_pc_wrap();
    test_back_to_back();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
